// File: rtl/efc_shdes_pkg.sv
// efc_shdes_pkg
// Shared definitions for the efuse-cluster serial deserializer:
//   state_t    - deserializer FSM states (IDLE, SHIFT)
//   DEF_WIDTH  - default data word width
//   DEF_CNT_W  - default bit-counter width (2^DEF_CNT_W > DEF_WIDTH)
package efc_shdes_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

endpackage

// File: rtl/efc_shdes_obuf.sv
// efc_shdes_obuf
// One-entry valid/ready holding register between the deserializer and the
// efuse controller. A load is accepted when the buffer is empty or is being
// emptied in the same cycle; otherwise the incoming word is dropped and the
// buffered word is kept untouched.
// Ports:
//   clk, rst   - core clock, synchronous active-high reset
//   load       - a completed word is offered this cycle
//   load_data  - the offered word
//   load_par   - parity-error flag travelling with the offered word
//   rdy        - consumer ready
//   data       - buffered word, stable while vld=1
//   vld        - buffer holds a word
//   par        - parity-error flag of the buffered word
//   drop       - one-cycle pulse: the offered word was dropped (overflow)
module efc_shdes_obuf
  import efc_shdes_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_par,
  input  logic             rdy,
  output logic [WIDTH-1:0] data,
  output logic             vld,
  output logic             par,
  output logic             drop
);

  logic accept;

  // A transfer in the same cycle frees the entry, so the load still fits.
  assign accept = load & (~vld | rdy);
  assign drop   = load & vld & ~rdy;

  // Holding register: a new load wins over the emptying transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      vld  <= 1'b0;
      par  <= 1'b0;
    end else if (accept) begin
      data <= load_data;
      vld  <= 1'b1;
      par  <= load_par;
    end else if (vld & rdy) begin
      vld  <= 1'b0;
      par  <= 1'b0;
    end
  end

endmodule

// File: rtl/efc_shdes.sv
// efc_shdes
// Serial-to-parallel deserializer fed by the efuse-cluster edge detectors.
// Collects MSB-first words from serial-clock strobes inside a frame and
// hands them to the efuse controller through a one-entry valid/ready buffer.
// Optional feature macro: EFC_SHDES_PARITY_EN -- each word is followed by an
// even-parity bit and par_err reports a mismatch for the presented word.
// Ports:
//   clk, rst   - core clock, synchronous active-high reset
//   sclk_rise  - serial clock rising-edge strobe
//   frm_rise   - frame start strobe
//   frm_fall   - frame end strobe
//   sdata      - serial data, sampled with sclk_rise
//   word_rdy   - consumer ready
//   clr_err    - clears the sticky ovf_err / frm_err flags
//   word       - assembled word, stable while word_vld=1
//   word_vld   - word valid
//   busy       - frame in progress (SHIFT state)
//   ovf_err    - sticky: a completed word was dropped
//   frm_err    - sticky: frame ended or restarted mid-word
//   par_err    - parity mismatch of the presented word (0 without parity)
module efc_shdes
  import efc_shdes_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_rise,
  input  logic             frm_rise,
  input  logic             frm_fall,
  input  logic             sdata,
  input  logic             word_rdy,
  input  logic             clr_err,
  output logic [WIDTH-1:0] word,
  output logic             word_vld,
  output logic             busy,
  output logic             ovf_err,
  output logic             frm_err,
  output logic             par_err
);

  // Count value of the strobe that completes a word: the parity bit follows
  // the last data bit when parity is enabled.
`ifdef EFC_SHDES_PARITY_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt, shifted, load_data;
  logic             load, load_par, frm_set, ovf_set;
  logic             ovf_q, frm_q;

  assign shifted = {sreg[WIDTH-2:0], sdata};

  // With parity the data bits are already in sreg when the parity bit
  // arrives; the incoming bit is the parity itself.
`ifdef EFC_SHDES_PARITY_EN
  assign load_data = sreg;
  assign load_par  = (^sreg) ^ sdata;
`else
  assign load_data = shifted;
  assign load_par  = 1'b0;
`endif

  // State, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
    end
  end

  // Next-state logic. In SHIFT a frame restart overrides a same-cycle bit;
  // otherwise the bit is shifted first and a frame end is judged on the
  // resulting count, so a word completed by that bit is not truncated.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    load      = 1'b0;
    frm_set   = 1'b0;
    case (state)
      IDLE: begin
        if (frm_rise) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (frm_rise) begin
          cnt_nxt = '0;
          frm_set = (cnt != '0);
        end else begin
          if (sclk_rise) begin
            sreg_nxt = shifted;
            if (cnt == CNT_LAST) begin
              cnt_nxt = '0;
              load    = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
          if (frm_fall) begin
            state_nxt = IDLE;
            frm_set   = (cnt_nxt != '0);
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  efc_shdes_obuf #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_par  (load_par),
    .rdy       (word_rdy),
    .data      (word),
    .vld       (word_vld),
    .par       (par_err),
    .drop      (ovf_set)
  );

  // Sticky error flags: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      frm_q <= 1'b0;
    end else begin
      if (ovf_set)      ovf_q <= 1'b1;
      else if (clr_err) ovf_q <= 1'b0;
      if (frm_set)      frm_q <= 1'b1;
      else if (clr_err) frm_q <= 1'b0;
    end
  end

  assign ovf_err = ovf_q;
  assign frm_err = frm_q;
  assign busy    = (state == SHIFT);

endmodule

// File: tb/tb_efc_shdes.sv
// tb_efc_shdes
// Self-checking bench for efc_shdes (WIDTH=8). Expected words are queued
// when their bits are driven and compared when the DUT transfers them.
// Honours EFC_SHDES_PARITY_EN when the design is built with it.
module tb_efc_shdes;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, sclk_rise, frm_rise, frm_fall, sdata, word_rdy, clr_err;
  logic [WIDTH-1:0] word;
  logic             word_vld, busy, ovf_err, frm_err, par_err;

  int checks = 0;
  int passes = 0;
  logic [WIDTH:0] expq[$];

  always #5 clk = ~clk;

  efc_shdes #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk_rise (sclk_rise),
    .frm_rise  (frm_rise),
    .frm_fall  (frm_fall),
    .sdata     (sdata),
    .word_rdy  (word_rdy),
    .clr_err   (clr_err),
    .word      (word),
    .word_vld  (word_vld),
    .busy      (busy),
    .ovf_err   (ovf_err),
    .frm_err   (frm_err),
    .par_err   (par_err)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One clock cycle of strobes; outputs are stable when this returns.
  task automatic applyStimulus(input logic sr, input logic sd, input logic fr,
                               input logic ff);
    sclk_rise = sr;
    sdata     = sd;
    frm_rise  = fr;
    frm_fall  = ff;
    @(posedge clk);
    #1;
    sclk_rise = 1'b0;
    sdata     = 1'b0;
    frm_rise  = 1'b0;
    frm_fall  = 1'b0;
  endtask

  function automatic logic expPar(input logic [WIDTH-1:0] w, input logic pbit);
`ifdef EFC_SHDES_PARITY_EN
    return (^w) ^ pbit;
`else
    return 1'b0;
`endif
  endfunction

  // Sends one word MSB first (plus its parity bit when enabled); the
  // completing strobe optionally carries frm_fall.
  task automatic sendWord(input logic [WIDTH-1:0] w, input logic pbit,
                          input logic fall_on_last);
    logic last;
    for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef EFC_SHDES_PARITY_EN
      last = 1'b0;
`else
      last = (i == 0) && fall_on_last;
`endif
      applyStimulus(1'b1, w[i], 1'b0, last);
    end
`ifdef EFC_SHDES_PARITY_EN
    applyStimulus(1'b1, pbit, 1'b0, fall_on_last);
`endif
  endtask

  task automatic sendBits(input logic [WIDTH-1:0] w, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, w[WIDTH-1-i], 1'b0, 1'b0);
  endtask

  task automatic expectWord(input logic [WIDTH-1:0] w, input logic pbit);
    expq.push_back({expPar(w, pbit), w});
  endtask

  task automatic clearErrors();
    clr_err = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    clr_err = 1'b0;
  endtask

  // Scoreboard: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && word_vld && word_rdy) begin
      if (expq.size() == 0) begin
        checkOutput("sb_unexpected_word", {56'd0, word}, 64'hDEAD);
      end else begin
        logic [WIDTH:0] e;
        e = expq.pop_front();
        checkOutput("sb_word", word, e[WIDTH-1:0]);
        checkOutput("sb_par", par_err, e[WIDTH]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] rw;
    rst = 1'b1; sclk_rise = 1'b0; frm_rise = 1'b0; frm_fall = 1'b0;
    sdata = 1'b0; word_rdy = 1'b0; clr_err = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_vld", word_vld, 0);
    checkOutput("rst_word", word, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ovf", ovf_err, 0);
    checkOutput("rst_frm", frm_err, 0);
    checkOutput("rst_par", par_err, 0);
    rst = 1'b0;

    // Basic word 0xB2, valid for exactly one cycle
    word_rdy = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("basic_busy", busy, 1);
    expectWord(8'hB2, 1'b0);
    sendWord(8'hB2, 1'b0, 1'b0);
    checkOutput("basic_vld_rise", word_vld, 1);
    checkOutput("basic_word", word, 8'hB2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("basic_vld_fall", word_vld, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("basic_idle", busy, 0);
    checkOutput("basic_no_frm", frm_err, 0);
    checkOutput("basic_no_ovf", ovf_err, 0);

    // Overflow: second word dropped while the first is held
    word_rdy = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    expectWord(8'hA5, ^8'hA5);
    sendWord(8'hA5, ^8'hA5, 1'b0);
    sendWord(8'h3C, ^8'h3C, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_word_kept", word, 8'hA5);
    checkOutput("ovf_vld", word_vld, 1);
    checkOutput("ovf_flag", ovf_err, 1);
    word_rdy = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_drained", word_vld, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    clearErrors();
    checkOutput("ovf_cleared", ovf_err, 0);

    // Truncated frame, then a clean frame
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(8'hFF, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("trunc_vld", word_vld, 0);
    checkOutput("trunc_frm", frm_err, 1);
    checkOutput("trunc_busy", busy, 0);
    clearErrors();
    checkOutput("trunc_cleared", frm_err, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    expectWord(8'h5A, ^8'h5A);
    sendWord(8'h5A, ^8'h5A, 1'b1);
    checkOutput("trunc_next_word", word, 8'h5A);
    checkOutput("trunc_next_frm", frm_err, 0);

    // Completing strobe coincides with frame end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    expectWord(8'hC3, ^8'hC3);
    sendWord(8'hC3, ^8'hC3, 1'b1);
    checkOutput("coll_vld", word_vld, 1);
    checkOutput("coll_word", word, 8'hC3);
    checkOutput("coll_frm", frm_err, 0);
    checkOutput("coll_busy", busy, 0);

    // Restart with a same-cycle bit at cnt=3: bit dropped, count restarts
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(8'hFF, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("restart_frm", frm_err, 1);
    checkOutput("restart_busy", busy, 1);
    expectWord(8'h69, ^8'h69);
    sendWord(8'h69, ^8'h69, 1'b1);
    checkOutput("restart_word", word, 8'h69);
    clearErrors();

    // Reset mid-frame with a word pending
    word_rdy = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    expectWord(8'h96, ^8'h96);
    sendWord(8'h96, ^8'h96, 1'b0);
    sendBits(8'hF0, 4);
    checkOutput("midrst_pending", word_vld, 1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    expq.delete();
    checkOutput("midrst_vld", word_vld, 0);
    checkOutput("midrst_word", word, 0);
    checkOutput("midrst_busy", busy, 0);
    rst = 1'b0;
    word_rdy = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("idle_stray_vld", word_vld, 0);
    checkOutput("idle_stray_busy", busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    expectWord(8'h81, ^8'h81);
    sendWord(8'h81, ^8'h81, 1'b1);
    checkOutput("post_rst_word", word, 8'h81);

`ifdef EFC_SHDES_PARITY_EN
    // Good and bad parity, then a frame ending before the parity bit
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    expectWord(8'hB2, 1'b0);
    sendWord(8'hB2, 1'b0, 1'b0);
    checkOutput("par_good", par_err, 0);
    expectWord(8'hB2, 1'b1);
    sendWord(8'hB2, 1'b1, 1'b1);
    checkOutput("par_bad", par_err, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(8'hB2, WIDTH);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("par_trunc_vld", word_vld, 0);
    checkOutput("par_trunc_frm", frm_err, 1);
    clearErrors();
`else
    // Nine strobes: one word plus one bit of the next
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    expectWord(8'hB2, 1'b0);
    sendWord(8'hB2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("nine_vld_gone", word_vld, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("nine_frm", frm_err, 1);
    checkOutput("nine_par", par_err, 0);
    clearErrors();
`endif

    // Random back-to-back words in one frame
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      rw = WIDTH'($urandom_range(0, 255));
      expectWord(rw, ^rw);
      sendWord(rw, ^rw, (k == 5));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("final_frm", frm_err, 0);
    checkOutput("final_ovf", ovf_err, 0);
    checkOutput("sb_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/efc_shdes.md
Name: efc_shdes

Overview:
- Serial-to-parallel deserializer directly downstream of the efuse-cluster synchronizer/edge detectors.
- Consumes single-cycle rise/fall strobes of an externally clocked serial interface: serial clock edges, frame strobe edges and the synchronized data bit, all already in the `clk` domain.
- Assembles MSB-first words and hands them to the efuse controller through a valid/ready handshake with a one-entry output buffer.
- Flags overflow, truncated frames and, optionally, parity errors.

Parameters:
- WIDTH, 32, data word width in bits, 2..64.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  core clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sclk_rise  input  1  one-cycle strobe: serial clock rising edge, from the edge detector.
- frm_rise  input  1  one-cycle strobe: frame strobe asserted (frame start).
- frm_fall  input  1  one-cycle strobe: frame strobe deasserted (frame end).
- sdata  input  1  synchronized serial data, sampled when sclk_rise=1.
- word_rdy  input  1  consumer ready.
- clr_err  input  1  clears the sticky error flags.
- word  output  WIDTH  assembled word; stable while word_vld=1.
- word_vld  output  1  word valid.
- busy  output  1  1 while in SHIFT.
- ovf_err  output  1  sticky: a completed word was dropped.
- frm_err  output  1  sticky: a frame ended or restarted mid-word.
- par_err  output  1  parity mismatch for the word currently presented.

Behaviour:
- Reset: state=IDLE; shift register, bit count, word, word_vld, ovf_err, frm_err and par_err all 0. A reset mid-frame discards all state and any pending word.
- IDLE state:
  - sclk_rise and sdata are ignored.
  - frm_rise moves to SHIFT with cnt=0.
- SHIFT state:
  - On sclk_rise: sreg <= {sreg[WIDTH-2:0], sdata}; cnt <= cnt+1.
  - On the sclk_rise where cnt==WIDTH-1, the word is complete: the buffer is loaded with {sreg[WIDTH-2:0], sdata} and cnt wraps to 0.
  - A frame may carry any number of words back to back.
- Load latency: word_vld rises on the cycle after the completing sclk_rise.
- Output handshake:
  - A transfer occurs on a cycle where word_vld & word_rdy; word_vld then drops the next cycle unless a new load happens in the same cycle.
  - word_rdy may be held high permanently.
- Full-buffer case:
  - Completion while word_vld=1 and word_rdy=0: the new word is dropped, ovf_err is set, and the buffered word is kept unchanged.
  - Completion in the same cycle as a transfer: the load succeeds with no error.
- Frame end: frm_fall returns the block to IDLE.
  - If cnt!=0 after processing any same-cycle sclk_rise, the partial word is discarded and frm_err is set.
- Simultaneous sclk_rise and frm_fall: the bit is shifted first, then the frame closes. If that bit completes a word, the word is delivered and frm_err is not set.
- frm_rise while in SHIFT: restart with cnt=0; frm_err is set if cnt!=0. frm_rise has priority over a same-cycle sclk_rise, and that bit is discarded.
- Simultaneous frm_rise and frm_fall: treated as frm_rise.
- clr_err clears ovf_err and frm_err the next cycle. A same-cycle error set wins over the clear.
- busy = (state==SHIFT).

Optional Feature:
- Macro: EFC_SHDES_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit, so the bit counter runs 0..WIDTH.
  - The data is loaded on the parity bit's sclk_rise.
  - par_err = (^data) ^ parity_bit, registered alongside word and valid while word_vld=1.
  - A frame ending between the last data bit and the parity bit counts as a truncated word and sets frm_err.
- Undefined:
  - No parity bit is expected.
  - par_err is tied to 0.

Decomposition:
- Package efc_shdes_pkg: state enum {IDLE, SHIFT}; default WIDTH and CNT_W localparams.
- One sub-module, efc_shdes_obuf: the one-entry valid/ready holding register with a load/drop/overflow indication. All other logic is flat in efc_shdes.

Test Plan:
- Basic word (WIDTH=8): frm_rise, then 8 sclk_rise with bits 1,0,1,1,0,0,1,0, word_rdy=1 → word=8'hB2, word_vld high exactly 1 cycle starting the cycle after the 8th strobe; no errors.
- Overflow: word_rdy=0, two back-to-back words 8'hA5 then 8'h3C → word stays 8'hA5 and ovf_err=1. Raise word_rdy → transfer A5, then word_vld=0. clr_err → ovf_err=0.
- Truncated frame: frm_rise, 5 sclk_rise, frm_fall → no word_vld, frm_err=1, busy=0. A following full frame delivers its word correctly with cnt restarted from 0.
- Edge collision: 8th sclk_rise in the same cycle as frm_fall → word delivered, frm_err=0. Separately, frm_rise with sclk_rise at cnt=3 → bit dropped, frm_err=1, cnt=0.
- Reset mid-frame: rst asserted after 4 bits with word_vld=1 pending → all outputs 0 next cycle; stray sclk_rise strobes in IDLE produce nothing.
- Parity (EFC_SHDES_PARITY_EN): word 8'hB2 with parity 0 → par_err=0; the same word with parity 1 → par_err=1. Without the macro, 9 strobes yield one word plus 1 bit of the next word.
